// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 scan controller.
//  state_t     : scan sequencer states
//  OE_ACTIVE / OE_BLANK : panel output-enable polarity (active low)
//  LAT_ACTIVE  : panel latch polarity (active high)
//  max3()      : constant helper used to size the phase timer
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOW,
    HIGH,
    SETTLE,
    LATCH,
    DISPLAY,
    GAP
  } state_t;

  localparam logic OE_ACTIVE  = 1'b0;
  localparam logic OE_BLANK   = 1'b1;
  localparam logic LAT_ACTIVE = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hub75_phase_timer.sv
// Loadable down-counter that times one scan phase.
//  clk   in  : clock
//  rst   in  : asynchronous active-high reset
//  start in  : load the counter; the phase begins on the following cycle
//  load  in  : phase length in cycles (>=1)
//  done  out : high during the last cycle of the phase (one pulse per start)
module hub75_phase_timer #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] load,
  output logic             done
);

  logic [CNT_W-1:0] cnt;
  logic             running;

  // start wins over an expiring phase so back-to-back phases need no idle cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      cnt     <= load - 1'b1;
      running <= 1'b1;
    end else if (running) begin
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - 1'b1;
    end
  end

  assign done = running && (cnt == '0);

endmodule

// File: rtl/hub75_scan_controller.sv
// HUB75 scan controller for a two-half-panel, 1/ROWS_HALF scan LED matrix.
// Fetches upper/lower pixel pairs from a frame-buffer read port, shifts them
// out on the panel clock, latches the row, sets the row address and lights
// the row for ON_CYCLES.
//  CLOCK_50   in  : system clock
//  RESET      in  : asynchronous active-high reset
//  enable     in  : run scanning, sampled in IDLE and at the end of each row
//  pix_addr   out : frame-buffer read address {row, col}
//  pix_rgb1   in  : upper-half pixel {b,g,r}, valid one cycle after pix_addr
//  pix_rgb2   in  : lower-half pixel {b,g,r}, same timing
//  rgb1/rgb2  out : panel colour data
//  addr       out : panel row address
//  clk        out : panel shift clock
//  lat        out : panel latch (active high)
//  oe         out : panel output enable (active low)
//  frame_done out : one-cycle pulse in the gap after the last row is shown
module hub75_scan_controller
  import hub75_pkg::*;
#(
  parameter int COLS       = 64,
  parameter int ROWS_HALF  = 16,
  parameter int CLK_DIV    = 1,
  parameter int LAT_CYCLES = 2,
  parameter int ON_CYCLES  = 512
) (
  input  logic                                     CLOCK_50,
  input  logic                                     RESET,
  input  logic                                     enable,
  output logic [$clog2(ROWS_HALF)+$clog2(COLS)-1:0] pix_addr,
  input  logic [2:0]                               pix_rgb1,
  input  logic [2:0]                               pix_rgb2,
  output logic [2:0]                               rgb1,
  output logic [2:0]                               rgb2,
  output logic [$clog2(ROWS_HALF)-1:0]             addr,
  output logic                                     clk,
  output logic                                     lat,
  output logic                                     oe,
  output logic                                     frame_done
);

  localparam int RW = $clog2(ROWS_HALF);
  localparam int CW = $clog2(COLS);
  localparam int TW = $clog2(max3(CLK_DIV, LAT_CYCLES, ON_CYCLES) + 1);

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS_HALF - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [TW-1:0] LD_DIV   = TW'(CLK_DIV);
  localparam logic [TW-1:0] LD_LAT   = TW'(LAT_CYCLES);
  localparam logic [TW-1:0] LD_ON    = TW'(ON_CYCLES);

  state_t        state, state_d;
  logic [RW-1:0] row, row_d;
  logic [CW-1:0] col, col_d;
  logic          tmr_start;
  logic [TW-1:0] tmr_load;
  logic          tmr_done;
  logic          low_first;

  hub75_phase_timer #(
    .CNT_W (TW)
  ) u_timer (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .start (tmr_start),
    .load  (tmr_load),
    .done  (tmr_done)
  );

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_d;
      row   <= row_d;
      col   <= col_d;
    end
  end

  always_comb begin
    state_d   = state;
    row_d     = row;
    col_d     = col;
    tmr_start = 1'b0;
    tmr_load  = '0;

    case (state)
      IDLE: begin
        if (enable) begin
          state_d = FETCH;
          col_d   = '0;
        end
      end
      FETCH:   state_d = LOW;
      LOW:     if (tmr_done) state_d = HIGH;
      HIGH: begin
        if (tmr_done) begin
          if (col == COL_LAST) begin
            state_d = SETTLE;
          end else begin
            col_d   = col + 1'b1;
            state_d = FETCH;
          end
        end
      end
      SETTLE:  state_d = LATCH;
      LATCH:   if (tmr_done) state_d = DISPLAY;
      DISPLAY: if (tmr_done) state_d = GAP;
      GAP: begin
        row_d   = (row == ROW_LAST) ? '0 : row + 1'b1;
        col_d   = '0;
        state_d = enable ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // every timed phase is entered from a different state, so a state change
    // is the cue to arm the timer for the phase being entered
    if (state_d != state) begin
      case (state_d)
        LOW, HIGH: begin
          tmr_start = 1'b1;
          tmr_load  = LD_DIV;
        end
        LATCH: begin
          tmr_start = 1'b1;
          tmr_load  = LD_LAT;
        end
        DISPLAY: begin
          tmr_start = 1'b1;
          tmr_load  = LD_ON;
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from the next state so each pin is valid for the
  // whole of the state it belongs to.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      pix_addr   <= '0;
      rgb1       <= '0;
      rgb2       <= '0;
      addr       <= '0;
      clk        <= 1'b0;
      lat        <= ~LAT_ACTIVE;
      oe         <= OE_BLANK;
      frame_done <= 1'b0;
      low_first  <= 1'b0;
    end else begin
      clk        <= (state_d == HIGH);
      lat        <= (state_d == LATCH) ? LAT_ACTIVE : ~LAT_ACTIVE;
      oe         <= (state_d == DISPLAY) ? OE_ACTIVE : OE_BLANK;
      frame_done <= (state_d == GAP) && (row == ROW_LAST);
      low_first  <= (state_d == LOW) && (state != LOW);
      if (state_d == FETCH) pix_addr <= {row_d, col_d};
      // frame-buffer data for the FETCH address arrives during the first LOW cycle
      if (low_first) begin
        rgb1 <= pix_rgb1;
        rgb2 <= pix_rgb2;
      end
      // address moves in SETTLE, where the panel is guaranteed blanked
      if (state_d == SETTLE) addr <= row;
    end
  end

endmodule

// File: tb/tb_hub75_scan_controller.sv
module tb_hub75_scan_controller;

  localparam int COLS       = 4;
  localparam int ROWS_HALF  = 16;
  localparam int CLK_DIV    = 1;
  localparam int LAT_CYCLES = 2;
  localparam int ON_CYCLES  = 8;
  localparam int RW         = $clog2(ROWS_HALF);
  localparam int AW         = RW + $clog2(COLS);
  localparam int ROW_PERIOD = COLS * (1 + 2 * CLK_DIV) + LAT_CYCLES + ON_CYCLES + 2;

  logic          CLOCK_50;
  logic          RESET;
  logic          enable;
  logic [AW-1:0] pix_addr;
  logic [2:0]    pix_rgb1, pix_rgb2;
  logic [2:0]    rgb1, rgb2;
  logic [RW-1:0] addr;
  logic          clk, lat, oe, frame_done;

  hub75_scan_controller #(
    .COLS       (COLS),
    .ROWS_HALF  (ROWS_HALF),
    .CLK_DIV    (CLK_DIV),
    .LAT_CYCLES (LAT_CYCLES),
    .ON_CYCLES  (ON_CYCLES)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .enable     (enable),
    .pix_addr   (pix_addr),
    .pix_rgb1   (pix_rgb1),
    .pix_rgb2   (pix_rgb2),
    .rgb1       (rgb1),
    .rgb2       (rgb2),
    .addr       (addr),
    .clk        (clk),
    .lat        (lat),
    .oe         (oe),
    .frame_done (frame_done)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // frame buffer: random image, synchronous read with one cycle latency
  logic [2:0] mem1 [ROWS_HALF*COLS];
  logic [2:0] mem2 [ROWS_HALF*COLS];

  always @(posedge CLOCK_50) begin
    pix_rgb1 <= mem1[pix_addr];
    pix_rgb2 <= mem2[pix_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3*COLS-1:0] exp_row_bits(input int r, input bit lower);
    logic [3*COLS-1:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++)
      v[3*c +: 3] = lower ? mem2[r*COLS + c] : mem1[r*COLS + c];
    return v;
  endfunction

  // ---------------- panel-side observer / reference model ----------------
  int                cyc = 0;
  logic              p_clk, p_lat, p_oe;
  logic [RW-1:0]     p_addr;
  int                sidx, hi_cnt, lat_cnt, low_cnt, last_fall;
  logic [3*COLS-1:0] got1, got2;
  int                exp_row = 0;
  int                rows_done = 0;
  int                frames = 0;
  int                rises_total = 0;
  int                row_start = 0;
  bit                have_start = 0;

  task automatic monitor_loop();
    forever begin
      @(negedge CLOCK_50);
      cyc++;
      if (RESET) begin
        sidx = 0; hi_cnt = 0; lat_cnt = 0; low_cnt = 0; last_fall = 0;
        got1 = '0; got2 = '0;
        exp_row = 0; have_start = 0;
        p_clk = clk; p_lat = lat; p_oe = oe; p_addr = addr;
      end else begin
        if (lat && !oe) chk("lat_oe_overlap", 32'(1), 32'(0));
        if (addr != p_addr) chk("addr_change_blanked", 32'({p_oe, oe}), 32'(2'b11));

        if (clk && !p_clk) begin
          rises_total++;
          if (sidx == 0) begin
            if (have_start && enable) chk("row_period", 32'(cyc - row_start), 32'(ROW_PERIOD));
            row_start  = cyc;
            have_start = 1;
          end
          if (sidx < COLS) begin
            got1[3*sidx +: 3] = rgb1;
            got2[3*sidx +: 3] = rgb2;
          end
          sidx++;
        end
        if (clk) hi_cnt++;
        if (!clk && p_clk) begin
          chk("clk_high_width", 32'(hi_cnt), 32'(CLK_DIV));
          hi_cnt    = 0;
          last_fall = cyc;
        end
        if (!enable) have_start = 0;

        if (lat && !p_lat) begin
          chk("lat_after_last_fall", 32'(cyc - last_fall), 32'(1));
          chk("shift_count", 32'(sidx), 32'(COLS));
          chk("latch_addr", 32'(addr), 32'(exp_row));
          chk("rgb1_row_data", 32'(got1), 32'(exp_row_bits(exp_row, 1'b0)));
          chk("rgb2_row_data", 32'(got2), 32'(exp_row_bits(exp_row, 1'b1)));
        end
        if (lat) lat_cnt++;
        if (!lat && p_lat) begin
          chk("lat_width", 32'(lat_cnt), 32'(LAT_CYCLES));
          chk("oe_on_after_latch", 32'(oe), 32'(0));
          lat_cnt = 0;
        end

        if (!oe) low_cnt++;
        if (oe && !p_oe) begin
          chk("oe_low_width", 32'(low_cnt), 32'(ON_CYCLES));
          chk("frame_done_in_gap", 32'(frame_done), 32'(exp_row == ROWS_HALF - 1));
          if (exp_row == ROWS_HALF - 1) frames++;
          exp_row = (exp_row + 1) % ROWS_HALF;
          rows_done++;
          low_cnt = 0;
          sidx    = 0;
        end else if (frame_done) begin
          chk("frame_done_stray", 32'(1), 32'(0));
        end

        p_clk = clk; p_lat = lat; p_oe = oe; p_addr = addr;
      end
    end
  endtask

  task automatic wait_rows(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (rows_done < target && n < budget) begin
      @(posedge CLOCK_50);
      n++;
    end
    #1;
    chk(tag, 32'(rows_done), 32'(target));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  rd, rt, n, drop_col;
    bit  found;

    RESET  = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < ROWS_HALF*COLS; i++) begin
      mem1[i] = 3'($urandom);
      mem2[i] = 3'($urandom);
    end
    fork
      monitor_loop();
    join_none

    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("reset_oe", 32'(oe), 32'(1));
    chk("reset_lat", 32'(lat), 32'(0));
    chk("reset_clk", 32'(clk), 32'(0));
    chk("reset_addr", 32'(addr), 32'(0));
    chk("reset_pix_addr", 32'(pix_addr), 32'(0));
    chk("reset_rgb1", 32'(rgb1), 32'(0));
    chk("reset_rgb2", 32'(rgb2), 32'(0));
    chk("reset_frame_done", 32'(frame_done), 32'(0));

    #1 RESET = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    #1;
    chk("idle_oe", 32'(oe), 32'(1));
    chk("idle_clk", 32'(clk), 32'(0));

    // one full frame plus the first row of the next (addr wraps to 0)
    enable = 1'b1;
    wait_rows(ROWS_HALF + 1, (ROWS_HALF + 1) * ROW_PERIOD + 20, "rows_first_frame");
    chk("frames_after_first_frame", 32'(frames), 32'(1));

    // drop enable part-way through shifting row 5
    drop_col = $urandom_range(1, COLS - 1);
    found = 0;
    n = 0;
    while (!found && n < 8 * ROW_PERIOD) begin
      @(posedge CLOCK_50);
      #1;
      n++;
      if (exp_row == 5 && sidx == drop_col) found = 1;
    end
    chk("reach_row5_shift", 32'(found), 32'(1));
    enable = 1'b0;
    rd = rows_done;
    wait_rows(rd + 1, 2 * ROW_PERIOD, "row5_completes");
    rt = rises_total;
    repeat ($urandom_range(10, 40)) @(posedge CLOCK_50);
    #1;
    chk("idle_no_shift", 32'(rises_total - rt), 32'(0));
    chk("idle_blanked", 32'(oe), 32'(1));
    chk("idle_rows_stable", 32'(rows_done), 32'(rd + 1));

    // resume: scanning continues with row 6
    enable = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("resume_pix_addr", 32'(pix_addr), 32'(6 * COLS));
    wait_rows(rd + 3, 3 * ROW_PERIOD, "rows_after_resume");

    // asynchronous reset in the middle of DISPLAY
    found = 0;
    n = 0;
    while (!found && n < 2 * ROW_PERIOD) begin
      @(posedge CLOCK_50);
      #1;
      n++;
      if (!oe) found = 1;
    end
    chk("reach_display", 32'(found), 32'(1));
    repeat ($urandom_range(0, ON_CYCLES - 2)) @(posedge CLOCK_50);
    #2 RESET = 1'b1;
    #1;
    chk("midreset_oe", 32'(oe), 32'(1));
    chk("midreset_lat", 32'(lat), 32'(0));
    chk("midreset_clk", 32'(clk), 32'(0));
    chk("midreset_addr", 32'(addr), 32'(0));
    chk("midreset_pix_addr", 32'(pix_addr), 32'(0));
    repeat (2) @(posedge CLOCK_50);
    #2 RESET = 1'b0;
    rd = rows_done;
    wait_rows(rd + 3, 3 * ROW_PERIOD + 10, "rows_after_reset");

    repeat (5) @(posedge CLOCK_50);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
